// File: rtl/path_sequencer_if.sv
// Bus bundle between the path sequencer and its neighbours: program load
// port, run control from the top level, and the step outputs to navigation.
//
// Handshake: navigation must act on the COMMAND/PATH/COMPARE_DISTANCE outputs
// only while RUN_FLAG=2'b01. It reports completion by raising NEXT_FLAG, and
// only a 0->1 transition sampled during RUN counts. A level that is already
// high when the step starts is ignored. The sequencer then holds the finished
// step with RUN_FLAG=2'b10 for the settle time and presents the next entry.
// WR_EN is a single-cycle write that is accepted only while BUSY=0.
// START is accepted only while BUSY=0.
interface path_sequencer_if #(
  parameter int ADDR_W = 4
);
  logic              WR_EN;
  logic [ADDR_W-1:0] WR_ADDR;
  logic [20:0]       WR_DATA;
  logic [ADDR_W:0]   LENGTH;
  logic              START;
  logic              ABORT;
  logic              NEXT_FLAG;
  logic [4:0]        COMMAND;
  logic [7:0]        PATH;
  logic [7:0]        COMPARE_DISTANCE;
  logic [1:0]        RUN_FLAG;
  logic [ADDR_W-1:0] STEP;
  logic              BUSY;
  logic              DONE;
  logic              FAULT;
  logic [2:0]        state_dbg;

  modport master (
    output WR_EN, WR_ADDR, WR_DATA, LENGTH, START, ABORT, NEXT_FLAG,
    input  COMMAND, PATH, COMPARE_DISTANCE, RUN_FLAG, STEP, BUSY, DONE, FAULT,
           state_dbg
  );

  modport slave (
    input  WR_EN, WR_ADDR, WR_DATA, LENGTH, START, ABORT, NEXT_FLAG,
    output COMMAND, PATH, COMPARE_DISTANCE, RUN_FLAG, STEP, BUSY, DONE, FAULT,
           state_dbg
  );
endinterface

// File: rtl/path_sequencer.sv
// Path sequencer: stores a short navigation program and plays it out one step
// at a time. Each step advances on a NEXT_FLAG rising edge, then holds for a
// settle period. The block also provides start/abort control and a per-step
// timeout.
module path_sequencer #(
  parameter int DEPTH          = 16,
  parameter int ADDR_W         = 4,
  parameter int SETTLE_CYCLES  = 5000000,
  parameter int TIMEOUT_CYCLES = 1500000000
) (
  input  logic              CLK,
  input  logic              RST,
  path_sequencer_if.slave   bus
);

  // A single counter serves both RUN (timeout) and SETTLE (settle time).
  localparam int CNT_MAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    RUN      = 3'd2,
    SETTLE   = 3'd3,
    FAULT_ST = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [20:0]       mem [DEPTH];
  logic [20:0]       rd_data;
  logic [20:0]       entry_q;
  logic [ADDR_W-1:0] step_q;
  logic [ADDR_W:0]   len_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              load_phase_q;
  logic              next_q;
  logic              done_q;
  logic              fault_q;

  logic              busy;
  logic [1:0]        run_flag;
  logic              wr_ok;
  logic              next_rise;
  logic              last_step;
  logic              settle_end;
  logic              timeout_hit;
  logic              start_run;
  logic              load_entry;
  logic              step_inc;
  logic              set_fault;
  logic              done_d;

  assign wr_ok       = bus.WR_EN && !busy;
  assign next_rise   = bus.NEXT_FLAG && !next_q;
  assign last_step   = ({1'b0, step_q} == (len_q - 1'b1));
  assign settle_end  = (cnt_q == CNT_W'(SETTLE_CYCLES - 1));
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Program memory: writes only while idle, one-cycle registered read of the
  // entry addressed by the current step. Not reset; contents survive RST.
  always_ff @(posedge CLK) begin
    if (wr_ok) begin
      mem[bus.WR_ADDR] <= bus.WR_DATA;
    end
    rd_data <= mem[step_q];
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and per-transition action strobes.
  always_comb begin
    state_d    = state_q;
    start_run  = 1'b0;
    load_entry = 1'b0;
    step_inc   = 1'b0;
    set_fault  = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.START) begin
          if (bus.LENGTH == '0) begin
            done_d = 1'b1;
          end else begin
            start_run = 1'b1;
            state_d   = LOAD;
          end
        end
      end
      FAULT_ST: begin
        if (bus.ABORT) begin
          state_d = IDLE;
        end else if (bus.START) begin
          if (bus.LENGTH == '0) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            start_run = 1'b1;
            state_d   = LOAD;
          end
        end
      end
      LOAD: begin
        // First cycle issues the read; second cycle captures it.
        if (bus.ABORT) begin
          state_d = IDLE;
        end else if (load_phase_q) begin
          load_entry = 1'b1;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (bus.ABORT) begin
          state_d = IDLE;
        end else if (timeout_hit) begin
          set_fault = 1'b1;
          state_d   = FAULT_ST;
        end else if (next_rise) begin
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (bus.ABORT) begin
          state_d = IDLE;
        end else if (settle_end) begin
          if (last_step) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            step_inc = 1'b1;
            state_d  = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: step/length/fault registers, counter, entry outputs, edge history.
  always_ff @(posedge CLK) begin
    if (RST) begin
      entry_q      <= '0;
      step_q       <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      load_phase_q <= 1'b0;
      next_q       <= 1'b0;
      done_q       <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      next_q       <= bus.NEXT_FLAG;
      done_q       <= done_d;
      load_phase_q <= (state_q == LOAD) && !load_phase_q;
      if (start_run) begin
        len_q   <= (bus.LENGTH > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : bus.LENGTH;
        step_q  <= '0;
        fault_q <= 1'b0;
      end
      if (step_inc) begin
        step_q <= step_q + 1'b1;
      end
      if (set_fault) begin
        fault_q <= 1'b1;
      end
      if (load_entry) begin
        entry_q <= rd_data;
      end
      if ((state_d != state_q) || !((state_q == RUN) || (state_q == SETTLE))) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // State-decoded status outputs.
  always_comb begin
    busy     = 1'b0;
    run_flag = 2'b00;
    case (state_q)
      LOAD:    busy = 1'b1;
      RUN: begin
        busy     = 1'b1;
        run_flag = 2'b01;
      end
      SETTLE: begin
        busy     = 1'b1;
        run_flag = 2'b10;
      end
      default: ;
    endcase
  end

  assign bus.COMMAND          = entry_q[20:16];
  assign bus.PATH             = entry_q[15:8];
  assign bus.COMPARE_DISTANCE = entry_q[7:0];
  assign bus.RUN_FLAG         = run_flag;
  assign bus.STEP             = step_q;
  assign bus.BUSY             = busy;
  assign bus.DONE             = done_q;
  assign bus.FAULT            = fault_q;
  assign bus.state_dbg        = state_q;

endmodule
